// File: rtl/operand_fetch_if.sv
// Decode-side and execute-side valid/ready bundles of the operand fetch stage.
// slave is the stage's view, master is the view of whatever drives and consumes it.
interface operand_fetch_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_pc, out_ready,
        output in_ready, out_valid, out_op_a, out_op_b, out_rd, out_pc
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_pc, out_ready,
        input  in_ready, out_valid, out_op_a, out_op_b, out_rd, out_pc
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: reads the register file, forwards EX/MEM results, stalls on load-use,
// and hands registered operands to execute through a valid/ready handshake.
module operand_fetch #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    operand_fetch_if.slave      bus,
    output logic [4:0]          rf_rd_addr_a,
    output logic [4:0]          rf_rd_addr_b,
    input  logic [31:0]         rf_rd_data_a,
    input  logic [31:0]         rf_rd_data_b,
    input  logic                ex_wr_en,
    input  logic [4:0]          ex_rd,
    input  logic [31:0]         ex_wr_data,
    input  logic                ex_is_load,
    input  logic                mem_wr_en,
    input  logic [4:0]          mem_rd,
    input  logic [31:0]         mem_wr_data,
    output logic [CNT_W-1:0]    hazard_count
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    // S1: instruction waiting for register file data
    logic            s1_valid_q, s1_valid_d;
    logic [RW-1:0]   s1_rs1_q, s1_rs1_d;
    logic [RW-1:0]   s1_rs2_q, s1_rs2_d;
    logic [RW-1:0]   s1_rd_q, s1_rd_d;
    logic [XLEN-1:0] s1_pc_q, s1_pc_d;

    // S2: output register set
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_op_a_q, out_op_a_d;
    logic [XLEN-1:0] out_op_b_q, out_op_b_d;
    logic [RW-1:0]   out_rd_q, out_rd_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;

    logic [CNT_W-1:0] hazard_count_q, hazard_count_d;

    logic            s2_free_c;
    logic            hazard_c;
    logic            s1_adv_c;
    logic            in_ready_c;
    logic            accept_c;
    logic [XLEN-1:0] op_a_c;
    logic [XLEN-1:0] op_b_c;

    // Newest producer wins: non-load EX result, then MEM, then the register file; x0 is hardwired.
    function automatic logic [XLEN-1:0] forward(
        input logic [RW-1:0]   rs,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_en,
        input logic [RW-1:0]   ex_dst,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_en,
        input logic [RW-1:0]   mem_dst,
        input logic [XLEN-1:0] mem_data
    );
        logic [XLEN-1:0] val;
        val = rf_data;
        if (mem_en && (mem_dst != '0) && (mem_dst == rs)) val = mem_data;
        if (ex_en && (ex_dst != '0) && (ex_dst == rs))    val = ex_data;
        if (rs == '0)                                      val = '0;
        return val;
    endfunction

    always_comb begin
        s2_free_c  = !out_valid_q || bus.out_ready;
        hazard_c   = s1_valid_q && ex_is_load && ex_wr_en && (ex_rd != '0) &&
                     ((ex_rd == s1_rs1_q) || (ex_rd == s1_rs2_q));
        s1_adv_c   = s1_valid_q && !hazard_c && s2_free_c;
        in_ready_c = (!s1_valid_q || s1_adv_c) && !flush;
        accept_c   = bus.in_valid && in_ready_c;
    end

    // A held instruction keeps re-reading so its data tracks write-backs.
    always_comb begin
        if (s1_valid_q && !s1_adv_c) begin
            rf_rd_addr_a = s1_rs1_q;
            rf_rd_addr_b = s1_rs2_q;
        end else begin
            rf_rd_addr_a = bus.in_rs1;
            rf_rd_addr_b = bus.in_rs2;
        end
    end

    always_comb begin
        op_a_c = forward(s1_rs1_q, rf_rd_data_a, ex_wr_en && !ex_is_load, ex_rd, ex_wr_data,
                         mem_wr_en, mem_rd, mem_wr_data);
        op_b_c = forward(s1_rs2_q, rf_rd_data_b, ex_wr_en && !ex_is_load, ex_rd, ex_wr_data,
                         mem_wr_en, mem_rd, mem_wr_data);
    end

    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_rs1_d       = s1_rs1_q;
        s1_rs2_d       = s1_rs2_q;
        s1_rd_d        = s1_rd_q;
        s1_pc_d        = s1_pc_q;
        out_valid_d    = out_valid_q;
        out_op_a_d     = out_op_a_q;
        out_op_b_d     = out_op_b_q;
        out_rd_d       = out_rd_q;
        out_pc_d       = out_pc_q;
        hazard_count_d = hazard_count_q;

        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (accept_c) begin
                s1_valid_d = 1'b1;
                s1_rs1_d   = bus.in_rs1;
                s1_rs2_d   = bus.in_rs2;
                s1_rd_d    = bus.in_rd;
                s1_pc_d    = bus.in_pc;
            end else if (s1_adv_c) begin
                s1_valid_d = 1'b0;
            end

            if (s1_adv_c) begin
                out_valid_d = 1'b1;
                out_op_a_d  = op_a_c;
                out_op_b_d  = op_b_c;
                out_rd_d    = s1_rd_q;
                out_pc_d    = s1_pc_q;
            end else if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end

            if (hazard_c && (hazard_count_q != {CNT_W{1'b1}})) begin
                hazard_count_d = hazard_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_rs1_q       <= '0;
            s1_rs2_q       <= '0;
            s1_rd_q        <= '0;
            s1_pc_q        <= '0;
            out_valid_q    <= 1'b0;
            out_op_a_q     <= '0;
            out_op_b_q     <= '0;
            out_rd_q       <= '0;
            out_pc_q       <= '0;
            hazard_count_q <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_rs1_q       <= s1_rs1_d;
            s1_rs2_q       <= s1_rs2_d;
            s1_rd_q        <= s1_rd_d;
            s1_pc_q        <= s1_pc_d;
            out_valid_q    <= out_valid_d;
            out_op_a_q     <= out_op_a_d;
            out_op_b_q     <= out_op_b_d;
            out_rd_q       <= out_rd_d;
            out_pc_q       <= out_pc_d;
            hazard_count_q <= hazard_count_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_op_a  = out_op_a_q;
    assign bus.out_op_b  = out_op_b_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_pc    = out_pc_q;
    assign hazard_count  = hazard_count_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model, transaction-level reference model with
// scoreboard queue, and an independent output monitor.
module tb_operand_fetch;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic [31:0] pc;
    } exp_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
    } instr_t;

    logic clk;
    logic rst_n;
    logic flush;
    logic [4:0]  rf_rd_addr_a, rf_rd_addr_b;
    logic [31:0] rf_rd_data_a, rf_rd_data_b;
    logic        ex_wr_en, ex_is_load, mem_wr_en;
    logic [4:0]  ex_rd, mem_rd;
    logic [31:0] ex_wr_data, mem_wr_data;
    logic [CNT_W-1:0] hazard_count;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    operand_fetch_if of ();

    operand_fetch #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (of),
        .rf_rd_addr_a (rf_rd_addr_a),
        .rf_rd_addr_b (rf_rd_addr_b),
        .rf_rd_data_a (rf_rd_data_a),
        .rf_rd_data_b (rf_rd_data_b),
        .ex_wr_en     (ex_wr_en),
        .ex_rd        (ex_rd),
        .ex_wr_data   (ex_wr_data),
        .ex_is_load   (ex_is_load),
        .mem_wr_en    (mem_wr_en),
        .mem_rd       (mem_rd),
        .mem_wr_data  (mem_wr_data),
        .hazard_count (hazard_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered read with write-back bypass, x0 reads zero.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (wb_en && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
        rf_rd_data_a <= (wb_en && wb_addr != 5'd0 && wb_addr == rf_rd_addr_a) ? wb_data : rf[rf_rd_addr_a];
        rf_rd_data_b <= (wb_en && wb_addr != 5'd0 && wb_addr == rf_rd_addr_b) ? wb_data : rf[rf_rd_addr_b];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    exp_t             sb[$];
    bit               m_known = 0;
    bit               m_s1_valid = 0;
    instr_t           m_s1;
    bit               m_s2_valid = 0;
    logic [CNT_W-1:0] m_cnt = '0;

    // Value an instruction must see for register r this cycle: youngest producer wins.
    function automatic logic [31:0] newest(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (ex_wr_en && !ex_is_load && ex_rd == r) return ex_wr_data;
        if (mem_wr_en && mem_rd == r) return mem_wr_data;
        return rf[r];
    endfunction

    // Called right after inputs for a cycle are driven; checks and advances the model.
    task automatic eval();
        bit     s2_free, haz, adv, exp_rdy;
        logic [4:0] ea, eb;
        exp_t   e;
        #1;
        s2_free = !m_s2_valid || of.out_ready;
        haz     = m_s1_valid && ex_is_load && ex_wr_en && ex_rd != 5'd0 &&
                  (ex_rd == m_s1.rs1 || ex_rd == m_s1.rs2);
        adv     = m_s1_valid && !haz && s2_free;
        exp_rdy = (!m_s1_valid || adv) && !flush;
        ea      = (m_s1_valid && !adv) ? m_s1.rs1 : of.in_rs1;
        eb      = (m_s1_valid && !adv) ? m_s1.rs2 : of.in_rs2;
        if (m_known) begin
            chk("in_ready", 32'(of.in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(of.out_valid), 32'(m_s2_valid));
            chk("hazard_count", 32'(hazard_count), 32'(m_cnt));
            chk("rf_addr_a", 32'(rf_rd_addr_a), 32'(ea));
            chk("rf_addr_b", 32'(rf_rd_addr_b), 32'(eb));
        end
        if (!rst_n) begin
            m_known    = 1;
            m_s1_valid = 0;
            m_s2_valid = 0;
            m_cnt      = '0;
            sb.delete();
        end else if (m_known) begin
            if (flush) begin
                if (m_s2_valid && !of.out_ready) void'(sb.pop_back());
                m_s1_valid = 0;
                m_s2_valid = 0;
            end else begin
                if (adv) begin
                    e.op_a = newest(m_s1.rs1);
                    e.op_b = newest(m_s1.rs2);
                    e.rd   = m_s1.rd;
                    e.pc   = m_s1.pc;
                    sb.push_back(e);
                    m_s2_valid = 1;
                end else if (of.out_ready) begin
                    m_s2_valid = 0;
                end
                if (haz && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + CNT_W'(1);
                if (of.in_valid && exp_rdy) begin
                    m_s1_valid = 1;
                    m_s1 = '{rs1: of.in_rs1, rs2: of.in_rs2, rd: of.in_rd, pc: of.in_pc};
                end else if (adv) begin
                    m_s1_valid = 0;
                end
            end
        end
    endtask

    // Output monitor: scoreboard pop on handshake, stability while stalled.
    bit          prev_hold = 0;
    logic [31:0] p_a, p_b, p_pc;
    logic [4:0]  p_rd;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && m_known) begin
            if (prev_hold) begin
                chk("hold_op_a", of.out_op_a, p_a);
                chk("hold_op_b", of.out_op_b, p_b);
                chk("hold_rd", 32'(of.out_rd), 32'(p_rd));
                chk("hold_pc", of.out_pc, p_pc);
            end
            if (of.out_valid === 1'b1 && of.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("op_a", of.out_op_a, e.op_a);
                    chk("op_b", of.out_op_b, e.op_b);
                    chk("rd", 32'(of.out_rd), 32'(e.rd));
                    chk("pc", of.out_pc, e.pc);
                end
            end
            prev_hold = (of.out_valid === 1'b1) && !of.out_ready;
            p_a = of.out_op_a; p_b = of.out_op_b; p_rd = of.out_rd; p_pc = of.out_pc;
        end else begin
            prev_hold = 0;
        end
    end

    task automatic idle();
        of.in_valid = 0; of.in_rs1 = 0; of.in_rs2 = 0; of.in_rd = 0; of.in_pc = 0;
        of.out_ready = 1; flush = 0;
        ex_wr_en = 0; ex_rd = 0; ex_wr_data = 0; ex_is_load = 0;
        mem_wr_en = 0; mem_rd = 0; mem_wr_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] pc);
        of.in_valid = 1; of.in_rs1 = rs1; of.in_rs2 = rs2; of.in_rd = rd; of.in_pc = pc;
    endtask

    task automatic rand_inputs();
        of.in_valid  = ($urandom_range(0, 3) != 0);
        of.in_rs1    = 5'($urandom_range(0, 7));
        of.in_rs2    = 5'($urandom_range(0, 7));
        of.in_rd     = 5'($urandom_range(0, 31));
        of.in_pc     = $urandom;
        of.out_ready = ($urandom_range(0, 3) != 0);
        flush        = ($urandom_range(0, 31) == 0);
        ex_wr_en     = ($urandom_range(0, 1) == 1);
        ex_rd        = 5'($urandom_range(0, 7));
        ex_is_load   = ($urandom_range(0, 3) == 0);
        ex_wr_data   = $urandom;
        mem_wr_en    = ($urandom_range(0, 1) == 1);
        mem_rd       = 5'($urandom_range(0, 7));
        mem_wr_data  = $urandom;
        wb_en        = ($urandom_range(0, 1) == 1);
        wb_addr      = 5'($urandom_range(0, 7));
        wb_data      = $urandom;
    endtask

    task automatic cyc_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); idle(); eval();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        idle();
        rst_n = 0;
        @(negedge clk); eval();
        @(negedge clk); eval();
        @(negedge clk); rst_n = 1; idle(); eval();

        // Back-to-back flow
        @(negedge clk); idle(); wb_en = 1; wb_addr = 5'd5; wb_data = 32'h11; eval();
        @(negedge clk); idle(); wb_en = 1; wb_addr = 5'd6; wb_data = 32'h22; eval();
        @(negedge clk); idle(); issue(5'd5, 5'd6, 5'd7, 32'h100); eval();
        @(negedge clk); idle(); issue(5'd6, 5'd5, 5'd8, 32'h104); eval();
        cyc_idle(3);

        // Forward priority: EX over MEM, MEM alone, x0 ignores forwarding
        @(negedge clk); idle(); issue(5'd3, 5'd0, 5'd9, 32'h200); eval();
        @(negedge clk); idle(); ex_wr_en = 1; ex_rd = 5'd3; ex_wr_data = 32'hAAAA;
            mem_wr_en = 1; mem_rd = 5'd3; mem_wr_data = 32'hBBBB; eval();
        @(negedge clk); idle(); issue(5'd3, 5'd0, 5'd9, 32'h204); eval();
        @(negedge clk); idle(); mem_wr_en = 1; mem_rd = 5'd3; mem_wr_data = 32'hBBBB; eval();
        @(negedge clk); idle(); issue(5'd0, 5'd0, 5'd9, 32'h208); eval();
        @(negedge clk); idle(); ex_wr_en = 1; ex_rd = 5'd0; ex_wr_data = 32'hAAAA; eval();
        cyc_idle(2);

        // Load-use: one stall cycle, then MEM forwards the load data
        @(negedge clk); idle(); issue(5'd1, 5'd4, 5'd10, 32'h300); eval();
        @(negedge clk); idle(); ex_is_load = 1; ex_wr_en = 1; ex_rd = 5'd4; eval();
        @(negedge clk); idle(); mem_wr_en = 1; mem_rd = 5'd4; mem_wr_data = 32'h1234; eval();
        cyc_idle(2);

        // Backpressure with a write-back to the held instruction's source
        @(negedge clk); idle(); of.out_ready = 0; issue(5'd2, 5'd3, 5'd11, 32'h400); eval();
        @(negedge clk); idle(); of.out_ready = 0; issue(5'd2, 5'd5, 5'd12, 32'h404); eval();
        @(negedge clk); idle(); of.out_ready = 0; issue(5'd6, 5'd6, 5'd13, 32'h408);
            wb_en = 1; wb_addr = 5'd2; wb_data = 32'hCAFE; eval();
        @(negedge clk); idle(); of.out_ready = 0; eval();
        cyc_idle(3);

        // Flush with both stages full
        @(negedge clk); idle(); of.out_ready = 0; issue(5'd1, 5'd2, 5'd14, 32'h500); eval();
        @(negedge clk); idle(); of.out_ready = 0; issue(5'd3, 5'd4, 5'd15, 32'h504); eval();
        @(negedge clk); idle(); of.out_ready = 0; flush = 1; eval();
        @(negedge clk); idle(); issue(5'd5, 5'd6, 5'd16, 32'h508); eval();
        cyc_idle(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); rand_inputs(); eval();
        end
        cyc_idle(3);

        // Saturating stall counter, then reset in the middle of the stall
        @(negedge clk); idle(); issue(5'd4, 5'd0, 5'd17, 32'h600); eval();
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            @(negedge clk); idle(); ex_is_load = 1; ex_wr_en = 1; ex_rd = 5'd4;
            of.in_valid = 1; of.in_rs1 = 5'd1; eval();
        end
        chk("sat_count", 32'(hazard_count), 32'hFFFF);
        @(negedge clk); idle(); ex_is_load = 1; ex_wr_en = 1; ex_rd = 5'd4; rst_n = 0; eval();
        @(negedge clk); idle(); rst_n = 1;
        #1;
        chk("rst_out_valid", 32'(of.out_valid), 32'd0);
        chk("rst_op_a", of.out_op_a, 32'd0);
        chk("rst_op_b", of.out_op_b, 32'd0);
        chk("rst_rd", 32'(of.out_rd), 32'd0);
        chk("rst_pc", of.out_pc, 32'd0);
        chk("rst_count", 32'(hazard_count), 32'd0);
        chk("rst_in_ready", 32'(of.in_ready), 32'd1);
        eval();

        for (int i = 0; i < 200; i++) begin
            @(negedge clk); rand_inputs(); eval();
        end
        cyc_idle(5);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
